islemci_cekirdek: RTL and testbench
===================================

// Module: islemci_cekirdek
// PURPOSE
//  Multicycle RV32I integer core. Each instruction runs through three stages:
//  GETIR (fetch), COZYAZMACOKU (decode/register read), YURUTGERIYAZ (execute/memory/writeback).
//  It connects to a single-port word memory (anabellek) based at 0x8000_0000.
//  The memory has a combinational read and a write that commits on the clock edge.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC value loaded by reset
//  VERI_BIT  32             data and instruction width
//  ADRES_BIT 32             address width
// PORTS
//  clk              in   1   single clock; all state updates on posedge
//  rst              in   1   asynchronous, active-low reset
//  bellek_adres     out  32  memory address (PC in GETIR, effective address for load/store)
//  bellek_oku_veri  in   32  combinational read data for bellek_adres
//  bellek_yaz_veri  out  32  store data
//  bellek_yaz       out  1   write strobe; memory writes the full word on posedge while high
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): PC=RESET_PC; simdiki_asama_r=GETIR; x0..x31=0; buyruk_r=0.
//    Output values during reset: bellek_adres=RESET_PC, bellek_yaz=0, bellek_yaz_veri=0.
//  - Visible internal names (the bench probes these):
//    - yazmac_obegi[0:31]: register file.
//    - simdiki_asama_r[1:0]: current stage. Encoding GETIR=0, COZYAZMACOKU=1, YURUTGERIYAZ=2,
//      each declared as a localparam.
//    - ilerle_cmb: combinational "stage completes this cycle" signal.
//  - The stage advances on posedge only when ilerle_cmb=1. Otherwise the stage and all state hold.
//  - GETIR:
//    - bellek_adres=PC.
//    - buyruk_r<=bellek_oku_veri.
//    - ilerle_cmb=1.
//  - COZYAZMACOKU:
//    - Decode buyruk_r.
//    - Latch rs1/rs2 values and the sign-extended immediate.
//    - ilerle_cmb=1.
//  - YURUTGERIYAZ:
//    - ALU result is written to rd; writes to x0 are discarded.
//    - PC<=PC+4, or the branch/jump target.
//    - Next stage is GETIR.
//  - Load/store take 2 cycles in YURUTGERIYAZ:
//    - Cycle 1: bellek_adres=rs1+imm, ilerle_cmb=0, bekle_r set.
//    - Cycle 2: ilerle_cmb=1. lw writes bellek_oku_veri to rd; sw drives bellek_yaz=1 with rs2.
//    - All other instructions have ilerle_cmb=1 in every stage, so latency is exactly 3 cycles.
//  - Supported instructions:
//    - add sub sll slt sltu xor srl sra or and
//    - addi slti sltiu xori ori andi slli srli srai
//    - lui auipc jal jalr (jalr target LSB cleared)
//    - beq bne blt bge bltu bgeu
//    - lw sw
//  - Arithmetic is 32-bit modulo 2^32; carry is dropped. Shifts use the low 5 bits of the amount.
//  - Illegal or unsupported opcode: executes as a NOP (PC+4, no register or memory write).
//  - Misaligned addresses: the low 2 bits are ignored (word access).
//  - Reset asserted mid-instruction: the instruction is aborted with no partial writeback
//    and the core restarts at GETIR.
//  - bellek_yaz is high only in cycle 2 of sw.
// CONFIGURATION
//  ISLEMCI_MUL_EN defined:
//    - Adds RV32M mul, mulh, mulhu, mulhsu (opcode 0110011, funct7=0000001).
//    - These take 2 YURUTGERIYAZ cycles: ilerle_cmb=0 in the first cycle.
//    - Writeback is the low or high 32 bits of the 64-bit product.
//  ISLEMCI_MUL_EN undefined: funct7=0000001 encodings are NOPs.
// TESTING
//  Common setup: x1=0x0eff45cd, x4=0xf00fff00, program at 0x8000_0000.
//  Stage order: every instruction must show GETIR -> COZYAZMACOKU -> YURUTGERIYAZ on cycles
//  where ilerle_cmb=1.
//  1. add x21,x1,x4 (0x00408ab3) -> x21=0xff0f44cd.
//     sub x22,x1,x4 (0x40408b33) -> x22=0x1eef46cd.
//  2. or x23 (0x0040ebb3) -> 0xfeffffcd.
//     and x24 (0x0040fc33) -> 0x000f4500.
//     xor x25 (0x0040ccb3) -> 0xfef0bacd.
//  3. sw x4,8(x1) with x1=0x8000_0000 -> mem[0x8000_0008]=0xf00fff00.
//     bellek_yaz pulses for 1 cycle.
//     Then lw x5,8(x1) -> x5=0xf00fff00, with 1 cycle at ilerle_cmb=0.
//  4. beq x0,x0,+8 -> PC skips one word.
//     jal x1,-4 -> x1=PC+4, PC=PC-4.
//  5. rst pulsed low mid-YURUTGERIYAZ of add x21 -> x21 unchanged, PC=0x8000_0000,
//     simdiki_asama_r=GETIR.
//  6. addi x0,x0,5 -> x0 stays 0.
//     With ISLEMCI_MUL_EN: mul x6,x4,x4 -> x6=low 32 bits of the product.

Source files
------------

// File: rtl/islemci_cekirdek_if.sv
// Memory bus of the core: one single-port word memory with a combinational
// read and a write that commits on the clock edge.
//   bellek_adres     core -> mem  word address (PC or load/store address)
//   bellek_oku_veri  mem -> core  read data for bellek_adres
//   bellek_yaz_veri  core -> mem  store data
//   bellek_yaz       core -> mem  full-word write strobe
interface islemci_cekirdek_if #(
   parameter int VERI_BIT  = 32,
   parameter int ADRES_BIT = 32
);
   logic [ADRES_BIT-1:0] bellek_adres;
   logic [VERI_BIT-1:0]  bellek_oku_veri;
   logic [VERI_BIT-1:0]  bellek_yaz_veri;
   logic                 bellek_yaz;

   modport master (output bellek_adres, bellek_yaz_veri, bellek_yaz, input bellek_oku_veri);
   modport slave  (input bellek_adres, bellek_yaz_veri, bellek_yaz, output bellek_oku_veri);
endinterface

// File: rtl/islemci_cekirdek.sv
// Multicycle RV32I core: GETIR (fetch) -> COZYAZMACOKU (decode/read regs)
// -> YURUTGERIYAZ (execute/memory/writeback). lw/sw spend two cycles in
// YURUTGERIYAZ; everything else completes in exactly three cycles.
// Ports:
//   clk  clock, all state on posedge
//   rst  asynchronous active-low reset
//   bus  memory bus (master side), see islemci_cekirdek_if
// Optional feature: define ISLEMCI_MUL_EN to add mul/mulh/mulhsu/mulhu
// (two execute cycles). Without it those encodings behave as NOPs.
module islemci_cekirdek #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter int          VERI_BIT  = 32,
   parameter int          ADRES_BIT = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   islemci_cekirdek_if.master     bus
);
   localparam logic [1:0] GETIR        = 2'd0;
   localparam logic [1:0] COZYAZMACOKU = 2'd1;
   localparam logic [1:0] YURUTGERIYAZ = 2'd2;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;

   logic [VERI_BIT-1:0] pc_r, buyruk_r, rs1_r, rs2_r, imm_r;
   logic [1:0]          simdiki_asama_r;
   logic                bekle_r;
   logic [VERI_BIT-1:0] yazmac_obegi [0:31];
   logic                ilerle_cmb;

   logic [6:0] opkod, f7;
   logic [2:0] f3;
   logic [4:0] rd_a, rs1_a, rs2_a;
   assign opkod = buyruk_r[6:0];
   assign rd_a  = buyruk_r[11:7];
   assign f3    = buyruk_r[14:12];
   assign rs1_a = buyruk_r[19:15];
   assign rs2_a = buyruk_r[24:20];
   assign f7    = buyruk_r[31:25];

   // Legality decides NOP-vs-execute; anything not listed stays a NOP.
   logic gecerli, bellek_op, uzun_op;
`ifdef ISLEMCI_MUL_EN
   logic carp_op;
`endif
   always_comb begin
      gecerli   = 1'b0;
      bellek_op = 1'b0;
`ifdef ISLEMCI_MUL_EN
      carp_op   = 1'b0;
`endif
      case (opkod)
         OP_R: begin
            if (f7 == 7'b0000000) gecerli = 1'b1;
            else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) gecerli = 1'b1;
`ifdef ISLEMCI_MUL_EN
            else if (f7 == 7'b0000001 && !f3[2]) begin
               gecerli = 1'b1;
               carp_op = 1'b1;
            end
`endif
         end
         OP_I: begin
            if (f3 == 3'b001)      gecerli = (f7 == 7'b0000000);
            else if (f3 == 3'b101) gecerli = (f7 == 7'b0000000 || f7 == 7'b0100000);
            else                   gecerli = 1'b1;
         end
         OP_LUI, OP_AUIPC, OP_JAL: gecerli = 1'b1;
         OP_JALR: gecerli = (f3 == 3'b000);
         OP_B:    gecerli = (f3[2:1] != 2'b01);
         OP_LW, OP_SW: begin
            gecerli   = (f3 == 3'b010);
            bellek_op = gecerli;
         end
         default: ;
      endcase
   end

`ifdef ISLEMCI_MUL_EN
   assign uzun_op = bellek_op | carp_op;
`else
   assign uzun_op = bellek_op;
`endif

   // Sign-extended immediate, latched in COZYAZMACOKU.
   logic [VERI_BIT-1:0] imm_cmb;
   always_comb begin
      case (opkod)
         OP_SW:            imm_cmb = {{20{buyruk_r[31]}}, buyruk_r[31:25], buyruk_r[11:7]};
         OP_B:             imm_cmb = {{19{buyruk_r[31]}}, buyruk_r[31], buyruk_r[7],
                                      buyruk_r[30:25], buyruk_r[11:8], 1'b0};
         OP_LUI, OP_AUIPC: imm_cmb = {buyruk_r[31:12], 12'b0};
         OP_JAL:           imm_cmb = {{11{buyruk_r[31]}}, buyruk_r[31], buyruk_r[19:12],
                                      buyruk_r[20], buyruk_r[30:21], 1'b0};
         default:          imm_cmb = {{20{buyruk_r[31]}}, buyruk_r[31:20]};
      endcase
   end

   // ALU: register operand for R-type, immediate otherwise.
   logic [VERI_BIT-1:0] op_b, alu_sonuc, ea;
   assign op_b = (opkod == OP_R) ? rs2_r : imm_r;
   assign ea   = rs1_r + imm_r;
   always_comb begin
      case (f3)
         3'b000:  alu_sonuc = (opkod == OP_R && f7[5]) ? rs1_r - op_b : rs1_r + op_b;
         3'b001:  alu_sonuc = rs1_r << op_b[4:0];
         3'b010:  alu_sonuc = VERI_BIT'($signed(rs1_r) < $signed(op_b));
         3'b011:  alu_sonuc = VERI_BIT'(rs1_r < op_b);
         3'b100:  alu_sonuc = rs1_r ^ op_b;
         3'b101:  alu_sonuc = f7[5] ? VERI_BIT'($signed(rs1_r) >>> op_b[4:0]) : rs1_r >> op_b[4:0];
         3'b110:  alu_sonuc = rs1_r | op_b;
         default: alu_sonuc = rs1_r & op_b;
      endcase
   end

   logic dal_al;
   always_comb begin
      case (f3)
         3'b000:  dal_al = (rs1_r == rs2_r);
         3'b001:  dal_al = (rs1_r != rs2_r);
         3'b100:  dal_al = ($signed(rs1_r) < $signed(rs2_r));
         3'b101:  dal_al = !($signed(rs1_r) < $signed(rs2_r));
         3'b110:  dal_al = (rs1_r < rs2_r);
         3'b111:  dal_al = !(rs1_r < rs2_r);
         default: dal_al = 1'b0;
      endcase
   end

`ifdef ISLEMCI_MUL_EN
   // 64x64 of the sign/zero-extended operands gives the exact low 64 bits
   // of the signed, unsigned or mixed product; registered in cycle 1.
   logic [63:0] a64, b64, carpim_cmb, carpim_r;
   assign a64 = {{32{(f3 == 3'b001 || f3 == 3'b010) & rs1_r[31]}}, rs1_r};
   assign b64 = {{32{(f3 == 3'b001) & rs2_r[31]}}, rs2_r};
   assign carpim_cmb = a64 * b64;
`endif

   logic                yaz_en;
   logic [VERI_BIT-1:0] yaz_deger, sonraki_pc;
   always_comb begin
      yaz_en     = 1'b0;
      yaz_deger  = alu_sonuc;
      sonraki_pc = pc_r + 32'd4;
      if (gecerli) begin
         case (opkod)
            OP_R: begin
               yaz_en = 1'b1;
`ifdef ISLEMCI_MUL_EN
               if (carp_op) yaz_deger = (f3 == 3'b000) ? carpim_r[31:0] : carpim_r[63:32];
`endif
            end
            OP_I:     yaz_en = 1'b1;
            OP_LUI:   begin yaz_en = 1'b1; yaz_deger = imm_r; end
            OP_AUIPC: begin yaz_en = 1'b1; yaz_deger = pc_r + imm_r; end
            OP_JAL:   begin yaz_en = 1'b1; yaz_deger = pc_r + 32'd4; sonraki_pc = pc_r + imm_r; end
            OP_JALR:  begin yaz_en = 1'b1; yaz_deger = pc_r + 32'd4; sonraki_pc = ea & ~32'h1; end
            OP_B:     if (dal_al) sonraki_pc = pc_r + imm_r;
            OP_LW:    begin yaz_en = 1'b1; yaz_deger = bus.bellek_oku_veri; end
            default: ;
         endcase
      end
   end

   logic yurut;
   assign yurut      = (simdiki_asama_r == YURUTGERIYAZ);
   // Long ops stall one cycle; bekle_r marks the second execute cycle.
   assign ilerle_cmb = (yurut && uzun_op) ? bekle_r : 1'b1;

   assign bus.bellek_adres    = (yurut && bellek_op) ? (ea & ~32'h3) : pc_r;
   assign bus.bellek_yaz      = yurut && bellek_op && (opkod == OP_SW) && bekle_r;
   assign bus.bellek_yaz_veri = bus.bellek_yaz ? rs2_r : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r            <= RESET_PC;
         simdiki_asama_r <= GETIR;
         buyruk_r        <= '0;
         rs1_r           <= '0;
         rs2_r           <= '0;
         imm_r           <= '0;
         bekle_r         <= 1'b0;
         for (int i = 0; i < 32; i++) yazmac_obegi[i] <= '0;
`ifdef ISLEMCI_MUL_EN
         carpim_r        <= '0;
`endif
      end else if (ilerle_cmb) begin
         case (simdiki_asama_r)
            GETIR: begin
               buyruk_r        <= bus.bellek_oku_veri;
               simdiki_asama_r <= COZYAZMACOKU;
            end
            COZYAZMACOKU: begin
               rs1_r           <= yazmac_obegi[rs1_a];
               rs2_r           <= yazmac_obegi[rs2_a];
               imm_r           <= imm_cmb;
               simdiki_asama_r <= YURUTGERIYAZ;
            end
            YURUTGERIYAZ: begin
               if (yaz_en && rd_a != 5'd0) yazmac_obegi[rd_a] <= yaz_deger;
               pc_r            <= sonraki_pc;
               bekle_r         <= 1'b0;
               simdiki_asama_r <= GETIR;
            end
            default: simdiki_asama_r <= GETIR;
         endcase
      end else begin
         bekle_r  <= 1'b1;
`ifdef ISLEMCI_MUL_EN
         carpim_r <= carpim_cmb;
`endif
      end
   end
endmodule

// File: tb/tb_islemci_cekirdek.sv
module tb_islemci_cekirdek;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   islemci_cekirdek_if bus ();
   islemci_cekirdek dut (.clk(clk), .rst(rst), .bus(bus));

   // Word memory at 0x8000_0000, loaded by the bench through its own port.
   logic [31:0] mem [0:255];
   logic        tb_we = 1'b0;
   logic [7:0]  tb_a  = '0;
   logic [31:0] tb_d  = '0;
   always @(posedge clk) begin
      if (tb_we) mem[tb_a] <= tb_d;
      else if (bus.bellek_yaz) mem[bus.bellek_adres[9:2]] <= bus.bellek_yaz_veri;
   end
   assign bus.bellek_oku_veri = mem[bus.bellek_adres[9:2]];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LUI = 7'b0110111, LW = 7'b0000011;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, R};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {im, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, rs1);
      return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3);
      return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
      return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
   endfunction

   task automatic yukle(input int a, input logic [31:0] d);
      tb_we = 1'b1; tb_a = 8'(a); tb_d = d;
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   // Runs one instruction: checks GETIR->COZYAZMACOKU->YURUTGERIYAZ on the
   // ilerle_cmb cycles, the cycle count and the number of write-strobe cycles.
   task automatic calistir(input string tag, input int exp_cyc, input int exp_yaz);
      int cyc = 0, yz = 0;
      logic [1:0] e = 2'd0;
      bit done = 0, sira = 1;
      while (!done && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (bus.bellek_yaz) yz++;
         if (dut.ilerle_cmb) begin
            if (dut.simdiki_asama_r != e) sira = 0;
            if (e == 2'd2) done = 1; else e++;
         end
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_order"}, 32'(sira), 32'd1);
      chk({tag, "_cycles"}, cyc, exp_cyc);
      chk({tag, "_wstrobe"}, yz, exp_yaz);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      yukle(0,  {20'h0eff4, 5'd1, LUI});
      yukle(1,  enc_i(12'h5cd, 5'd1, 3'b000, 5'd1, I));
      yukle(2,  {20'hf0100, 5'd4, LUI});
      yukle(3,  enc_i(12'hf00, 5'd4, 3'b000, 5'd4, I));
      yukle(4,  32'h00408ab3);
      yukle(5,  32'h40408b33);
      yukle(6,  32'h0040ebb3);
      yukle(7,  32'h0040fc33);
      yukle(8,  32'h0040ccb3);
      yukle(9,  enc_i(12'd5, 5'd0, 3'b000, 5'd0, I));
      yukle(10, enc_i(12'h404, 5'd4, 3'b101, 5'd26, I));
      yukle(11, enc_r(7'h00, 5'd1, 5'd4, 3'b010, 5'd27));
      yukle(12, enc_r(7'h00, 5'd1, 5'd4, 3'b011, 5'd28));
      yukle(13, {20'h80000, 5'd1, LUI});
      yukle(14, enc_s(12'd8, 5'd4, 5'd1));
      yukle(15, enc_i(12'd8, 5'd1, 3'b010, 5'd5, LW));
      yukle(16, enc_b(13'd8, 5'd0, 5'd0, 3'b000));
      yukle(17, enc_i(12'd1, 5'd0, 3'b000, 5'd7, I));
      yukle(18, enc_j(21'h1ffffc, 5'd1));

      // Reset state, sampled while reset is held
      chk("rst_pc", dut.pc_r, 32'h8000_0000);
      chk("rst_stage", 32'(dut.simdiki_asama_r), 32'd0);
      chk("rst_adres", bus.bellek_adres, 32'h8000_0000);
      chk("rst_yaz", 32'(bus.bellek_yaz), 32'd0);
      chk("rst_yaz_veri", bus.bellek_yaz_veri, 32'd0);
      chk("rst_buyruk", dut.buyruk_r, 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      for (int k = 0; k < 4; k++) calistir("setup", 3, 0);
      chk("x1_setup", dut.yazmac_obegi[1], 32'h0eff45cd);
      chk("x4_setup", dut.yazmac_obegi[4], 32'hf00fff00);
      calistir("add", 3, 0);   chk("add_x21", dut.yazmac_obegi[21], 32'hff0f44cd);
      calistir("sub", 3, 0);   chk("sub_x22", dut.yazmac_obegi[22], 32'h1eef46cd);
      calistir("or", 3, 0);    chk("or_x23",  dut.yazmac_obegi[23], 32'hfeffffcd);
      calistir("and", 3, 0);   chk("and_x24", dut.yazmac_obegi[24], 32'h000f4500);
      calistir("xor", 3, 0);   chk("xor_x25", dut.yazmac_obegi[25], 32'hfef0bacd);
      calistir("addi_x0", 3, 0); chk("x0_zero", dut.yazmac_obegi[0], 32'd0);
      calistir("srai", 3, 0);  chk("srai_x26", dut.yazmac_obegi[26], 32'hff00fff0);
      calistir("slt", 3, 0);   chk("slt_x27", dut.yazmac_obegi[27], 32'd1);
      calistir("sltu", 3, 0);  chk("sltu_x28", dut.yazmac_obegi[28], 32'd0);
      calistir("lui", 3, 0);   chk("lui_x1", dut.yazmac_obegi[1], 32'h8000_0000);
      calistir("sw", 4, 1);    chk("sw_mem", mem[2], 32'hf00fff00);
      calistir("lw", 4, 0);    chk("lw_x5", dut.yazmac_obegi[5], 32'hf00fff00);
      calistir("beq", 3, 0);   chk("beq_pc", dut.pc_r, 32'h8000_0048);
      calistir("jal", 3, 0);
      chk("jal_pc", dut.pc_r, 32'h8000_0044);
      chk("jal_x1", dut.yazmac_obegi[1], 32'h8000_004c);
      chk("skip_x7", dut.yazmac_obegi[7], 32'd0);

      // Restart; word 2 now holds the stored data, an illegal opcode (NOP)
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      for (int k = 0; k < 2; k++) calistir("re_setup", 3, 0);
      calistir("illegal", 3, 0);
      chk("illegal_pc", dut.pc_r, 32'h8000_000c);
      chk("illegal_x4", dut.yazmac_obegi[4], 32'd0);
      calistir("addi_neg", 3, 0);
      chk("addi_neg_x4", dut.yazmac_obegi[4], 32'hffffff00);

      // Reset asserted in the execute cycle of add x21
      @(negedge clk); chk("ab_getir", 32'(dut.simdiki_asama_r), 32'd0);
      @(negedge clk); chk("ab_coz", 32'(dut.simdiki_asama_r), 32'd1);
      @(negedge clk); chk("ab_yurut", 32'(dut.simdiki_asama_r), 32'd2);
      rst = 1'b0;
      #1;
      chk("ab_adres", bus.bellek_adres, 32'h8000_0000);
      @(posedge clk); #1;
      chk("ab_x21", dut.yazmac_obegi[21], 32'd0);
      chk("ab_pc", dut.pc_r, 32'h8000_0000);
      chk("ab_stage", 32'(dut.simdiki_asama_r), 32'd0);

      // RV32M encoding: a product with the option, a NOP without it
      yukle(0, {20'hf0100, 5'd4, LUI});
      yukle(1, enc_i(12'hf00, 5'd4, 3'b000, 5'd4, I));
      yukle(2, enc_r(7'h01, 5'd4, 5'd4, 3'b000, 5'd6));
      @(posedge clk); #1 rst = 1'b1;
      calistir("m_lui", 3, 0);
      calistir("m_addi", 3, 0);
`ifdef ISLEMCI_MUL_EN
      calistir("mul", 4, 0);
      chk("mul_x6", dut.yazmac_obegi[6], 32'he0010000);
`else
      calistir("mul_nop", 3, 0);
      chk("mul_nop_x6", dut.yazmac_obegi[6], 32'd0);
`endif
      chk("mul_pc", dut.pc_r, 32'h8000_000c);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
